// File: rtl/wb_txn_monitor.sv
// Passive classic-Wishbone transaction monitor feeding a first-word-fall-through event FIFO.
// Define WB_MON_TIMEOUT_EN to enable the no-ACK watchdog and its HOLD state.
module wb_txn_monitor #(
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32,
  parameter int DEPTH          = 16,
  parameter int LAT_W          = 8,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_W         = DAT_W / 8,
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST_SYNC,
  input  logic              CLR_IN,
  input  logic              WB_CYC_IN,
  input  logic              WB_STB_IN,
  input  logic              WB_WE_IN,
  input  logic              WB_ACK_IN,
  input  logic [SEL_W-1:0]  WB_SEL_IN,
  input  logic [ADR_W-1:0]  WB_ADR_IN,
  input  logic [DAT_W-1:0]  WB_DAT_WR_IN,
  input  logic [DAT_W-1:0]  WB_DAT_RD_IN,
  output logic              EVT_VALID_OUT,
  input  logic              EVT_READY_IN,
  output logic              EVT_RDWRB_OUT,
  output logic [SEL_W-1:0]  EVT_SEL_OUT,
  output logic [ADR_W-1:0]  EVT_ADR_OUT,
  output logic [DAT_W-1:0]  EVT_DATA_OUT,
  output logic [LAT_W-1:0]  EVT_LAT_OUT,
  output logic              EVT_ERR_OUT,
  output logic [CNT_W-1:0]  FIFO_COUNT_OUT,
  output logic [15:0]       DROP_CNT_OUT,
  output logic              OVERFLOW_OUT,
  output logic              ABORT_OUT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = 1 + SEL_W + ADR_W + DAT_W + LAT_W;
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wb_txn_monitor: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_txn_monitor: TIMEOUT_CYCLES must be >= 1");
  end

`ifdef WB_MON_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2} state_t;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // Error records report the watchdog limit, clipped to what the latency field can hold.
  localparam logic [LAT_W-1:0] TO_LAT =
    (longint'(TIMEOUT_CYCLES) >= (64'd1 << LAT_W)) ? LAT_MAX : LAT_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_r;
  logic            timeout_s;
  logic            rec_err_s;
  logic            err_mem_r [DEPTH];
  assign timeout_s = (wd_r == WD_W'(TIMEOUT_CYCLES));
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic               bus_act_s;
  logic               cap_we_r;
  logic [SEL_W-1:0]   cap_sel_r;
  logic [ADR_W-1:0]   cap_adr_r;
  logic [DAT_W-1:0]   cap_dat_r;
  logic [LAT_W-1:0]   lat_r;
  logic               push_s, abort_s, abort_r;
  logic [REC_W-1:0]   rec_s;
  logic [REC_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [15:0]        drop_r;
  logic               ovf_r;
  logic               pop_s, full_s, wr_en_s, drop_s;

  assign bus_act_s = WB_CYC_IN & WB_STB_IN;

  // State register
  always_ff @(posedge CLK) begin
    if (RST_SYNC) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic; ACK wins over a simultaneous strobe drop
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus_act_s && !WB_ACK_IN) state_nxt_s = ST_WAIT;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (WB_ACK_IN)       state_nxt_s = ST_IDLE;
        else if (!bus_act_s) state_nxt_s = ST_IDLE;
`ifdef WB_MON_TIMEOUT_EN
        else if (timeout_s)  state_nxt_s = ST_HOLD;
`endif
        else                 state_nxt_s = ST_WAIT;
      end
`ifdef WB_MON_TIMEOUT_EN
      ST_HOLD: begin
        if (!bus_act_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_HOLD;
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: record to push and abort request
  always_comb begin
    push_s  = 1'b0;
    abort_s = 1'b0;
    rec_s   = {~WB_WE_IN, WB_SEL_IN, WB_ADR_IN,
               (WB_WE_IN ? WB_DAT_WR_IN : WB_DAT_RD_IN), {LAT_W{1'b0}}};
`ifdef WB_MON_TIMEOUT_EN
    rec_err_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus_act_s && WB_ACK_IN) push_s = 1'b1;
        else                        push_s = 1'b0;
      end
      ST_WAIT: begin
        if (WB_ACK_IN) begin
          push_s = 1'b1;
          rec_s  = {~cap_we_r, cap_sel_r, cap_adr_r,
                    (cap_we_r ? cap_dat_r : WB_DAT_RD_IN), lat_r};
        end else if (!bus_act_s) begin
          abort_s = 1'b1;
`ifdef WB_MON_TIMEOUT_EN
        end else if (timeout_s) begin
          push_s    = 1'b1;
          rec_err_s = 1'b1;
          rec_s     = {~cap_we_r, cap_sel_r, cap_adr_r,
                       (cap_we_r ? cap_dat_r : {DAT_W{1'b0}}), TO_LAT};
`endif
        end else begin
          push_s = 1'b0;
        end
      end
      default: push_s = 1'b0;
    endcase
  end

  // Transfer capture and latency counting
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      cap_we_r  <= 1'b0;
      cap_sel_r <= {SEL_W{1'b0}};
      cap_adr_r <= {ADR_W{1'b0}};
      cap_dat_r <= {DAT_W{1'b0}};
      lat_r     <= {LAT_W{1'b0}};
`ifdef WB_MON_TIMEOUT_EN
      wd_r      <= {WD_W{1'b0}};
`endif
    end else if (state_r == ST_IDLE && bus_act_s && !WB_ACK_IN) begin
      cap_we_r  <= WB_WE_IN;
      cap_sel_r <= WB_SEL_IN;
      cap_adr_r <= WB_ADR_IN;
      cap_dat_r <= WB_DAT_WR_IN;
      lat_r     <= LAT_W'(1);
`ifdef WB_MON_TIMEOUT_EN
      wd_r      <= WD_W'(1);
`endif
    end else if (state_r == ST_WAIT && !WB_ACK_IN) begin
      if (lat_r != LAT_MAX) lat_r <= lat_r + LAT_W'(1);
`ifdef WB_MON_TIMEOUT_EN
      wd_r <= wd_r + WD_W'(1);
`endif
    end
  end

  // FIFO control; a push coincident with a clear is discarded
  always_comb begin
    pop_s   = (count_r != {CNT_W{1'b0}}) & EVT_READY_IN;
    full_s  = (count_r == CNT_W'(DEPTH));
    wr_en_s = push_s & ~RST_SYNC & ~CLR_IN & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
  end

  // FIFO pointers, occupancy and drop bookkeeping
  always_ff @(posedge CLK) begin
    if (RST_SYNC || CLR_IN) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      drop_r   <= 16'd0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        if (drop_r != 16'hFFFF) drop_r <= drop_r + 16'd1;
        ovf_r <= 1'b1;
      end
    end
  end

  // Record storage
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= rec_s;
`ifdef WB_MON_TIMEOUT_EN
      err_mem_r[wr_ptr_r] <= rec_err_s;
`endif
    end
  end

  // Abort pulse, suppressed by reset
  always_ff @(posedge CLK) begin
    if (RST_SYNC) abort_r <= 1'b0;
    else          abort_r <= abort_s;
  end

  assign EVT_VALID_OUT = (count_r != {CNT_W{1'b0}});
  assign {EVT_RDWRB_OUT, EVT_SEL_OUT, EVT_ADR_OUT, EVT_DATA_OUT, EVT_LAT_OUT} =
    EVT_VALID_OUT ? mem_r[rd_ptr_r] : {REC_W{1'b0}};
`ifdef WB_MON_TIMEOUT_EN
  assign EVT_ERR_OUT = EVT_VALID_OUT & err_mem_r[rd_ptr_r];
`else
  assign EVT_ERR_OUT = 1'b0;
`endif
  assign FIFO_COUNT_OUT = count_r;
  assign DROP_CNT_OUT   = drop_r;
  assign OVERFLOW_OUT   = ovf_r;
  assign ABORT_OUT      = abort_r;

endmodule

// File: tb/tb_wb_txn_monitor.sv
// Self-checking bench for wb_txn_monitor: transfer-level queue model with randomized traffic.
module tb_wb_txn_monitor;
  localparam int DEPTH = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, cyc, stb, we, ack, ready;
  logic [3:0]  sel;
  logic [31:0] adr, dwr, drd;
  logic        evt_valid, evt_rdwrb, evt_err, ovf, abort;
  logic [3:0]  evt_sel;
  logic [31:0] evt_adr, evt_data;
  logic [7:0]  evt_lat;
  logic [2:0]  fcount;
  logic [15:0] drop;

  wb_txn_monitor #(.ADR_W(32), .DAT_W(32), .DEPTH(DEPTH), .LAT_W(8),
                   .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .CLK(clk), .RST_SYNC(rst), .CLR_IN(clr),
    .WB_CYC_IN(cyc), .WB_STB_IN(stb), .WB_WE_IN(we), .WB_ACK_IN(ack),
    .WB_SEL_IN(sel), .WB_ADR_IN(adr), .WB_DAT_WR_IN(dwr), .WB_DAT_RD_IN(drd),
    .EVT_VALID_OUT(evt_valid), .EVT_READY_IN(ready), .EVT_RDWRB_OUT(evt_rdwrb),
    .EVT_SEL_OUT(evt_sel), .EVT_ADR_OUT(evt_adr), .EVT_DATA_OUT(evt_data),
    .EVT_LAT_OUT(evt_lat), .EVT_ERR_OUT(evt_err), .FIFO_COUNT_OUT(fcount),
    .DROP_CNT_OUT(drop), .OVERFLOW_OUT(ovf), .ABORT_OUT(abort));

  typedef struct {
    logic        rd;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [7:0]  lat;
    logic        err;
  } rec_t;

  rec_t exp_q[$];
  int   exp_drop = 0;
  bit   exp_ovf  = 1'b0;
  int   n_chk = 0, n_pass = 0;

  logic [78:0] head;
  assign head = {evt_valid, evt_rdwrb, evt_sel, evt_adr, evt_data, evt_lat, evt_err};

  function automatic logic [78:0] pack_exp(input rec_t e);
    return {1'b1, e.rd, e.sel, e.adr, e.dat, e.lat, e.err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded queue of records with drop-on-full semantics.
  task automatic model_cycle(input bit push, input rec_t r, input bit pop);
    bit was_full;
    was_full = (exp_q.size() == DEPTH);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (push) begin
      if (!was_full || pop) exp_q.push_back(r);
      else begin
        if (exp_drop < 65535) exp_drop++;
        exp_ovf = 1'b1;
      end
    end
  endtask

  // One classic transfer, ACK asserted 'lat' cycles after STB; returns #1 after the ACK edge.
  task automatic xfer(input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int lat);
    rec_t r;
    r.rd = ~w; r.sel = s; r.adr = a; r.dat = w ? wd : rd;
    r.lat = (lat > 255) ? 8'hFF : 8'(lat); r.err = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dwr = wd;
    ack = (lat == 0); drd = (lat == 0) ? rd : $urandom;
    for (int k = 1; k <= lat; k++) begin
      step();
      ack = (k == lat);
      drd = (k == lat) ? rd : $urandom;
    end
    step();
    model_cycle(1'b1, r, 1'b0);
    cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b1; we = 1'b1;
    ready = 1'b1; sel = 4'hF; adr = 32'h1234_0000; dwr = 32'h1; drd = 32'h2;
    step(); step(); step();
    n_chk++;
    if ({head, fcount, drop, ovf, abort} !== 100'd0)
      $display("FAIL reset_hold got head=%h cnt=%0d drop=%0d ovf=%b abort=%b want all 0",
               head, fcount, drop, ovf, abort);
    else n_pass++;
    rst = 1'b0; clr = 1'b0; cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0; ready = 1'b0;
    step();
    n_chk++;
    if ({head, fcount, drop, ovf, abort} !== 100'd0)
      $display("FAIL reset_release got head=%h cnt=%0d drop=%0d ovf=%b abort=%b want all 0",
               head, fcount, drop, ovf, abort);
    else n_pass++;
  endtask

  task automatic test_write_lat3();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h1F80_1810;
    dwr = 32'hDEAD_BEEF; ack = 1'b0; drd = $urandom;
    step(); step(); step();
    n_chk++;
    if (evt_valid !== 1'b0) $display("FAIL wr3_valid_early got %b want 0", evt_valid);
    else n_pass++;
    ack = 1'b1;
    step();
    cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0;
    n_chk++;
    if (head !== {1'b1, 1'b0, 4'hF, 32'h1F80_1810, 32'hDEAD_BEEF, 8'd3, 1'b0})
      $display("FAIL wr3_record got %h want %h", head,
               {1'b1, 1'b0, 4'hF, 32'h1F80_1810, 32'hDEAD_BEEF, 8'd3, 1'b0});
    else n_pass++;
    ready = 1'b1; step(); ready = 1'b0;
    n_chk++;
    if (fcount !== 3'd0) $display("FAIL wr3_pop got count %0d want 0", fcount);
    else n_pass++;
  endtask

  task automatic test_read_lat0();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'h3; adr = 32'h0000_0040;
    ack = 1'b1; drd = 32'h1234_5678; dwr = 32'hFFFF_FFFF;
    step();
    cyc = 1'b0; stb = 1'b0; ack = 1'b0;
    n_chk++;
    if (head !== {1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'h1234_5678, 8'd0, 1'b0})
      $display("FAIL rd0_record got %h want %h", head,
               {1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'h1234_5678, 8'd0, 1'b0});
    else n_pass++;
    ready = 1'b1; step(); ready = 1'b0;
    n_chk++;
    if (evt_valid !== 1'b0) $display("FAIL rd0_pop got valid %b want 0", evt_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    bit w;
    int l;
    for (int t = 0; t < 24; t++) begin
      w = 1'($urandom_range(0, 1));
      l = $urandom_range(0, 5);
      xfer(w, 4'($urandom), $urandom, $urandom, $urandom, l);
      n_chk++;
      if (fcount !== 3'(exp_q.size()))
        $display("FAIL rand_count t=%0d got %0d want %0d", t, fcount, exp_q.size());
      else n_pass++;
      if (exp_q.size() >= 3 || $urandom_range(0, 2) == 0 || t == 23) begin
        for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) begin
          n_chk++;
          if (head !== pack_exp(exp_q[0]))
            $display("FAIL rand_head t=%0d got %h want %h", t, head, pack_exp(exp_q[0]));
          else n_pass++;
          ready = 1'b1; step(); ready = 1'b0;
          model_cycle(1'b0, exp_q[0], 1'b1);
        end
      end
    end
  endtask

  task automatic test_overflow();
    rec_t dummy;
    dummy = '{default: '0};
    for (int t = 0; t < 6; t++)
      xfer(1'($urandom_range(0, 1)), 4'($urandom), 32'h100 + 32'(t), $urandom, $urandom,
           $urandom_range(0, 3));
    n_chk++;
    if ({fcount, drop, ovf} !== {3'd4, 16'd2, 1'b1})
      $display("FAIL ovf_state got cnt=%0d drop=%0d ovf=%b want cnt=4 drop=2 ovf=1",
               fcount, drop, ovf);
    else n_pass++;
    for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) begin
      n_chk++;
      if (head !== pack_exp(exp_q[0]))
        $display("FAIL ovf_drain i=%0d got %h want %h", i, head, pack_exp(exp_q[0]));
      else n_pass++;
      ready = 1'b1; step(); ready = 1'b0;
      model_cycle(1'b0, exp_q[0], 1'b1);
    end
    xfer(1'b1, 4'h1, 32'h200, 32'h5, 32'h0, 1);
    xfer(1'b0, 4'h2, 32'h204, 32'h0, 32'h6, 0);
    // CLR coincides with a zero-latency transfer, whose record must vanish
    clr = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b1; we = 1'b1; adr = 32'h208;
    step();
    clr = 1'b0; cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0;
    exp_q.delete(); exp_drop = 0; exp_ovf = 1'b0;
    n_chk++;
    if ({evt_valid, fcount, drop, ovf} !== {1'b0, 3'd0, 16'd0, 1'b0})
      $display("FAIL clr_state got v=%b cnt=%0d drop=%0d ovf=%b want all 0",
               evt_valid, fcount, drop, ovf);
    else n_pass++;
    step();
    n_chk++;
    if (fcount !== 3'd0) $display("FAIL clr_push got count %0d want 0", fcount);
    else n_pass++;
    model_cycle(1'b0, dummy, 1'b0);
  endtask

  task automatic test_full_pop_push();
    rec_t r;
    for (int t = 0; t < DEPTH; t++)
      xfer(1'b1, 4'hF, 32'h300 + 32'(t), $urandom, 32'h0, $urandom_range(0, 2));
    n_chk++;
    if (fcount !== 3'd4) $display("FAIL full_fill got count %0d want 4", fcount);
    else n_pass++;
    r.rd = 1'b0; r.sel = 4'hA; r.adr = 32'h3FF; r.dat = 32'h0BAD_F00D; r.lat = 8'd0; r.err = 1'b0;
    cyc = 1'b1; stb = 1'b1; ack = 1'b1; we = 1'b1; sel = 4'hA; adr = 32'h3FF; dwr = 32'h0BAD_F00D;
    ready = 1'b1;
    n_chk++;
    if (head !== pack_exp(exp_q[0]))
      $display("FAIL full_pop_head got %h want %h", head, pack_exp(exp_q[0]));
    else n_pass++;
    step();
    model_cycle(1'b1, r, 1'b1);
    cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0; ready = 1'b0;
    n_chk++;
    if ({fcount, drop, ovf} !== {3'd4, 16'(exp_drop), exp_ovf})
      $display("FAIL full_pushpop got cnt=%0d drop=%0d ovf=%b want cnt=4 drop=%0d ovf=%b",
               fcount, drop, ovf, exp_drop, exp_ovf);
    else n_pass++;
    for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) begin
      n_chk++;
      if (head !== pack_exp(exp_q[0]))
        $display("FAIL full_drain i=%0d got %h want %h", i, head, pack_exp(exp_q[0]));
      else n_pass++;
      ready = 1'b1; step(); ready = 1'b0;
      model_cycle(1'b0, exp_q[0], 1'b1);
    end
  endtask

  task automatic test_abort();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; ack = 1'b0; adr = 32'h400;
    step(); step(); step();
    stb = 1'b0;
    n_chk++;
    if (abort !== 1'b0) $display("FAIL abort_early got %b want 0", abort);
    else n_pass++;
    step();
    cyc = 1'b0;
    n_chk++;
    if ({abort, fcount} !== {1'b1, 3'd0})
      $display("FAIL abort_pulse got abort=%b cnt=%0d want abort=1 cnt=0", abort, fcount);
    else n_pass++;
    step();
    n_chk++;
    if (abort !== 1'b0) $display("FAIL abort_width got %b want 0", abort);
    else n_pass++;
    // Reset in the middle of a wait, then a stray ACK with STB low
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h404;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; stb = 1'b0; ack = 1'b1;
    exp_q.delete(); exp_drop = 0; exp_ovf = 1'b0;
    n_chk++;
    if (abort !== 1'b0) $display("FAIL rst_abort got %b want 0", abort);
    else n_pass++;
    step();
    cyc = 1'b0; ack = 1'b0;
    step();
    n_chk++;
    if ({abort, evt_valid, fcount} !== {1'b0, 1'b0, 3'd0})
      $display("FAIL rst_stray_ack got abort=%b v=%b cnt=%0d want 0 0 0",
               abort, evt_valid, fcount);
    else n_pass++;
  endtask

`ifdef WB_MON_TIMEOUT_EN
  task automatic test_timeout();
    rec_t r;
    int early;
    early = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'hA5A5_0000; dwr = 32'hCAFE_F00D;
    ack = 1'b0;
    for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
      step();
      if (fcount !== 3'd0) early++;
    end
    n_chk++;
    if (early !== 0) $display("FAIL to_early got %0d early cycles want 0", early);
    else n_pass++;
    step();
    r.rd = 1'b0; r.sel = 4'hF; r.adr = 32'hA5A5_0000; r.dat = 32'hCAFE_F00D;
    r.lat = 8'(TIMEOUT_CYCLES); r.err = 1'b1;
    model_cycle(1'b1, r, 1'b0);
    n_chk++;
    if (head !== pack_exp(r)) $display("FAIL to_record got %h want %h", head, pack_exp(r));
    else n_pass++;
    ack = 1'b1; step(); step(); ack = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    step();
    n_chk++;
    if ({fcount, abort} !== {3'd1, 1'b0})
      $display("FAIL to_late_ack got cnt=%0d abort=%b want cnt=1 abort=0", fcount, abort);
    else n_pass++;
    ready = 1'b1; step(); ready = 1'b0;
    model_cycle(1'b0, r, 1'b1);
  endtask
`else
  task automatic test_timeout();
    rec_t r;
    int early;
    early = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'h5; adr = 32'hA5A5_0004; ack = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (fcount !== 3'd0) early++;
    end
    n_chk++;
    if (early !== 0) $display("FAIL nto_early got %0d early cycles want 0", early);
    else n_pass++;
    ack = 1'b1; drd = 32'h7777_1111;
    step();
    cyc = 1'b0; stb = 1'b0; ack = 1'b0;
    r.rd = 1'b1; r.sel = 4'h5; r.adr = 32'hA5A5_0004; r.dat = 32'h7777_1111;
    r.lat = 8'd30; r.err = 1'b0;
    model_cycle(1'b1, r, 1'b0);
    n_chk++;
    if (head !== pack_exp(r)) $display("FAIL nto_record got %h want %h", head, pack_exp(r));
    else n_pass++;
    ready = 1'b1; step(); ready = 1'b0;
    model_cycle(1'b0, r, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_write_lat3();
    test_read_lat0();
    test_random();
    test_overflow();
    test_full_pop_push();
    test_abort();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_txn_monitor.md
WB_TXN_MONITOR -- requirements
Module: wb_txn_monitor

Interface
REQ-001 SHALL have parameter ADR_W, 32, Wishbone address width.
REQ-002 SHALL have parameter DAT_W, 32, data width (multiple of 8); SEL_W = DAT_W/8 derived.
REQ-003 SHALL have parameter DEPTH, 16, event FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter LAT_W, 8, latency field width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 256, watchdog limit (used only with WB_MON_TIMEOUT_EN).
REQ-006 SHALL have ports:
 CLK  in  1  single clock, all logic on rising edge.
 RST_SYNC  in  1  synchronous active-high reset.
 CLR_IN  in  1  flush FIFO, clear counters and sticky flags.
 WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_ACK_IN  in  1 each  observed classic Wishbone strobes.
 WB_SEL_IN  in  SEL_W  byte selects.
 WB_ADR_IN  in  ADR_W  address.
 WB_DAT_WR_IN / WB_DAT_RD_IN  in  DAT_W  write / read data.
 EVT_VALID_OUT  out  1  FIFO head valid.
 EVT_READY_IN  in  1  consumer pop.
 EVT_RDWRB_OUT  out  1  1=read, 0=write.
 EVT_SEL_OUT  out  SEL_W;  EVT_ADR_OUT  out  ADR_W;  EVT_DATA_OUT  out  DAT_W (write data for writes, read data for reads).
 EVT_LAT_OUT  out  LAT_W  cycles STB-start to ACK.
 EVT_ERR_OUT  out  1  record produced by timeout.
 FIFO_COUNT_OUT  out  log2(DEPTH)+1  occupancy.
 DROP_CNT_OUT  out  16  records lost to full FIFO.
 OVERFLOW_OUT  out  1  sticky, set on first drop.
 ABORT_OUT  out  1  one-cycle pulse on abandoned transfer.

Function
REQ-007 FSM states SHALL be IDLE, WAIT, HOLD (HOLD exists only with WB_MON_TIMEOUT_EN).
REQ-008 IDLE: CYC&STB&!ACK -> WAIT, capturing WE, SEL, ADR, DAT_WR, latency=1; CYC&STB&ACK -> push record latency 0, stay IDLE (read data from same cycle).
REQ-009 WAIT: ACK -> push record with DAT_RD sampled that cycle for reads, -> IDLE; latency increments each WAIT cycle without ACK, saturating at 2^LAT_W-1.
REQ-010 WAIT: CYC or STB low without ACK -> IDLE, no record, ABORT_OUT pulse next cycle.
REQ-011 Pushed record SHALL be visible at FIFO head one cycle after the ACK cycle (FWFT); EVT_VALID_OUT = count>0.
REQ-012 Pop SHALL occur on EVT_VALID_OUT&EVT_READY_IN; READY ignored when empty.
REQ-013 Push when full without pop SHALL drop the new record, increment DROP_CNT_OUT (saturate 0xFFFF), set OVERFLOW_OUT.
REQ-014 Push and pop in the same cycle when full SHALL both succeed, count unchanged, no drop.
REQ-015 Records SHALL leave in arrival order; pointers wrap modulo DEPTH.
REQ-016 CLR_IN SHALL empty FIFO, zero DROP_CNT_OUT and OVERFLOW_OUT next cycle; a push coincident with CLR_IN is discarded and not counted; FSM unaffected.

Reset
REQ-017 RST_SYNC SHALL force FSM IDLE, FIFO empty, all outputs 0 (EVT_* fields 0, counters 0, flags 0), overriding CLR_IN and bus activity.
REQ-018 Reset during WAIT/HOLD SHALL discard the in-flight transfer without record or ABORT pulse; a following ACK while IDLE with STB low is ignored.

Configuration
REQ-019 Macro WB_MON_TIMEOUT_EN defined: in WAIT, when latency reaches TIMEOUT_CYCLES without ACK, push record with EVT_ERR_OUT=1, latency=TIMEOUT_CYCLES (saturated), data field = captured write data or 0 for reads, -> HOLD; HOLD waits for CYC or STB low, ignoring ACK, then -> IDLE.
REQ-020 Macro undefined: no watchdog, no HOLD state, EVT_ERR_OUT tied 0, WAIT persists until ACK or abort.

Verification
REQ-021 Write ADR=0x1F801810 SEL=0xF DAT=0xDEADBEEF, ACK 3 cycles after STB -> one record RDWRB=0, LAT=3, DATA=0xDEADBEEF, VALID one cycle after ACK.
REQ-022 Read with ACK same cycle as STB, DAT_RD=0x12345678 -> RDWRB=1, LAT=0, DATA=0x12345678.
REQ-023 DEPTH=4, READY=0, six transfers -> COUNT=4, DROP_CNT=2, OVERFLOW=1; drain returns first four in order; CLR_IN zeroes all.
REQ-024 Full FIFO, pop and ACK same cycle -> COUNT stays 4, DROP_CNT unchanged, new record last.
REQ-025 STB dropped after 2 WAIT cycles -> no record, ABORT_OUT one cycle; RST_SYNC mid-WAIT -> no record, no ABORT.
REQ-026 WB_MON_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ACK -> ERR record LAT=8, late ACK ignored; macro undefined -> no record until ACK.
